// File: rtl/msrh_fpu_cmpl_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : msrh_fpu_cmpl_buf_if
// Brief    : Issue / completion / retire bundle for the FPU completion buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface msrh_fpu_cmpl_buf_if #(
    parameter int XLEN_W    = 64,
    parameter int NUM_UNITS = 2,
    parameter int DEPTH     = 4
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = IDX_W + 1;
    localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                          i_valid;
    logic                          o_ready;
    logic [SEL_W-1:0]              i_unit_sel;
    logic                          i_size_dw;
    logic [NUM_UNITS-1:0]          o_unit_valid;
    logic [TAG_W-1:0]              o_issue_tag;
    logic [NUM_UNITS-1:0]          i_cmpl_valid;
    logic [NUM_UNITS*TAG_W-1:0]    i_cmpl_tag;
    logic [NUM_UNITS*XLEN_W-1:0]   i_cmpl_result;
    logic [NUM_UNITS*5-1:0]        i_cmpl_fflags;
    logic                          i_flush;
    logic                          o_valid;
    logic                          i_ready;
    logic [XLEN_W-1:0]             o_result;
    logic [4:0]                    o_fflags;
    logic [4:0]                    o_fflags_acc;
    logic                          i_fflags_clr;
    logic                          o_busy;

    modport slave (
        input  i_valid, i_unit_sel, i_size_dw, i_cmpl_valid, i_cmpl_tag,
               i_cmpl_result, i_cmpl_fflags, i_flush, i_ready, i_fflags_clr,
        output o_ready, o_unit_valid, o_issue_tag, o_valid, o_result,
               o_fflags, o_fflags_acc, o_busy
    );

    modport master (
        output i_valid, i_unit_sel, i_size_dw, i_cmpl_valid, i_cmpl_tag,
               i_cmpl_result, i_cmpl_fflags, i_flush, i_ready, i_fflags_clr,
        input  o_ready, o_unit_valid, o_issue_tag, o_valid, o_result,
               o_fflags, o_fflags_acc, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/msrh_fpu_cmpl_buf.sv
`default_nettype none
// ============================================================================
// Module   : msrh_fpu_cmpl_buf
// Brief    : Reorders out-of-order FP sub-unit completions into program order.
// Revision : 1.0 - initial release
// ============================================================================
module msrh_fpu_cmpl_buf #(
    parameter int XLEN_W    = 64,
    parameter int NUM_UNITS = 2,
    parameter int DEPTH     = 4
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_reset_n,
    msrh_fpu_cmpl_buf_if.slave        bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = IDX_W + 1;
    localparam logic [IDX_W:0]       c_ptr_one  = 1;
    localparam logic [NUM_UNITS-1:0] c_unit_one = 1;

    logic [IDX_W:0]      r_head;
    logic [IDX_W:0]      r_tail;
    logic                r_epoch;
    logic [DEPTH-1:0]    r_alloc;
    logic [DEPTH-1:0]    r_done;
    logic [DEPTH-1:0]    r_size_dw;
    logic [XLEN_W-1:0]   r_result [DEPTH];
    logic [4:0]          r_fflags [DEPTH];
    logic [4:0]          r_fflags_acc;

    logic [IDX_W-1:0]    w_head_idx;
    logic [IDX_W-1:0]    w_tail_idx;
    logic                w_empty;
    logic                w_full;
    logic                w_ready;
    logic                w_issue;
    logic                w_out_valid;
    logic                w_retire;
    logic [XLEN_W-1:0]   w_head_result;
    logic [IDX_W-1:0]    w_cmpl_idx [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_cmpl_hit;

    assign w_head_idx  = r_head[IDX_W-1:0];
    assign w_tail_idx  = r_tail[IDX_W-1:0];
    assign w_empty     = (r_head == r_tail);
    assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_ready     = !w_full && !bus.i_flush;
    assign w_issue     = bus.i_valid && w_ready;
    assign w_out_valid = r_alloc[w_head_idx] && r_done[w_head_idx] && !bus.i_flush;
    assign w_retire    = w_out_valid && bus.i_ready;

    // A completion lands only if it belongs to the live epoch and its slot is still waiting.
    for (genvar gu = 0; gu < NUM_UNITS; gu++) begin : g_unit
        logic [TAG_W-1:0] w_tag;
        assign w_tag           = bus.i_cmpl_tag[gu*TAG_W +: TAG_W];
        assign w_cmpl_idx[gu]  = w_tag[IDX_W-1:0];
        assign w_cmpl_hit[gu]  = bus.i_cmpl_valid[gu] && (w_tag[IDX_W] == r_epoch) &&
                                 r_alloc[w_tag[IDX_W-1:0]] && !r_done[w_tag[IDX_W-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_epoch   <= 1'b0;
            r_alloc   <= '0;
            r_done    <= '0;
            r_size_dw <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i] <= '0;
                r_fflags[i] <= '0;
            end
        end else if (bus.i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_epoch <= ~r_epoch;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            if (w_issue) begin
                r_alloc[w_tail_idx]   <= 1'b1;
                r_done[w_tail_idx]    <= 1'b0;
                r_size_dw[w_tail_idx] <= bus.i_size_dw;
                r_tail                <= r_tail + c_ptr_one;
            end
            if (w_retire) begin
                r_alloc[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + c_ptr_one;
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_cmpl_hit[u]) begin
                    r_result[w_cmpl_idx[u]] <= bus.i_cmpl_result[u*XLEN_W +: XLEN_W];
                    r_fflags[w_cmpl_idx[u]] <= bus.i_cmpl_fflags[u*5 +: 5];
                    r_done[w_cmpl_idx[u]]   <= 1'b1;
                end
            end
        end
    end

    // Clear wins over a same-cycle retire.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fflags_acc <= '0;
        end else if (bus.i_fflags_clr) begin
            r_fflags_acc <= '0;
        end else if (w_retire) begin
            r_fflags_acc <= r_fflags_acc | r_fflags[w_head_idx];
        end
    end

    assign w_head_result    = r_result[w_head_idx];
    assign bus.o_ready      = w_ready;
    assign bus.o_unit_valid = w_issue ? (c_unit_one << bus.i_unit_sel) : '0;
    assign bus.o_issue_tag  = {r_epoch, w_tail_idx};
    assign bus.o_valid      = w_out_valid;
    assign bus.o_fflags     = r_fflags[w_head_idx];
    assign bus.o_fflags_acc = r_fflags_acc;
    assign bus.o_busy       = !w_empty;

    if (XLEN_W == 64) begin : g_nanbox
        assign bus.o_result = (w_out_valid && !r_size_dw[w_head_idx]) ?
                              {32'hFFFF_FFFF, w_head_result[31:0]} : w_head_result;
    end else begin : g_no_nanbox
        assign bus.o_result = w_head_result;
    end
endmodule
`default_nettype wire

// File: tb/tb_msrh_fpu_cmpl_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrh_fpu_cmpl_buf
// Brief    : Directed self-checking bench for the FPU completion buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msrh_fpu_cmpl_buf;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    msrh_fpu_cmpl_buf_if #(.XLEN_W(64), .NUM_UNITS(2), .DEPTH(4)) bus ();

    msrh_fpu_cmpl_buf #(.XLEN_W(64), .NUM_UNITS(2), .DEPTH(4)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && (&bus.i_cmpl_valid))
            assert (bus.i_cmpl_tag[2:0] != bus.i_cmpl_tag[5:3])
                else $error("illegal stimulus: two units completed the same tag");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmpl(input int u, input logic [2:0] tag, input logic [63:0] res,
                        input logic [4:0] fl);
        bus.i_cmpl_valid[u]         = 1'b1;
        bus.i_cmpl_tag[u*3 +: 3]    = tag;
        bus.i_cmpl_result[u*64 +: 64] = res;
        bus.i_cmpl_fflags[u*5 +: 5] = fl;
    endtask

    task automatic issue(input logic sel, input logic dw);
        bus.i_valid    = 1'b1;
        bus.i_unit_sel = sel;
        bus.i_size_dw  = dw;
    endtask

    logic [63:0] held_res;

    initial begin
        bus.i_valid = 0; bus.i_unit_sel = 0; bus.i_size_dw = 0;
        bus.i_cmpl_valid = 0; bus.i_cmpl_tag = 0; bus.i_cmpl_result = 0;
        bus.i_cmpl_fflags = 0; bus.i_flush = 0; bus.i_ready = 0; bus.i_fflags_clr = 0;
        rst_n = 0;
        tick(); tick();
        chk("rst_ready",  64'(bus.o_ready), 64'd1);
        chk("rst_valid",  64'(bus.o_valid), 64'd0);
        chk("rst_busy",   64'(bus.o_busy), 64'd0);
        chk("rst_uvalid", 64'(bus.o_unit_valid), 64'd0);
        chk("rst_acc",    64'(bus.o_fflags_acc), 64'd0);
        chk("rst_result", bus.o_result, 64'd0);
        rst_n = 1;
        tick();

        // Out-of-order completion, in-order retire
        issue(0, 1);
        #1;
        chk("A_uvalid", 64'(bus.o_unit_valid), 64'b01);
        chk("A_tag",    64'(bus.o_issue_tag), 64'd0);
        tick();
        issue(1, 1);
        #1;
        chk("B_uvalid", 64'(bus.o_unit_valid), 64'b10);
        chk("B_tag",    64'(bus.o_issue_tag), 64'd1);
        tick();
        bus.i_valid = 0;
        cmpl(1, 3'd1, 64'h2222_2222_2222_2222, 5'b10000);
        tick();
        bus.i_cmpl_valid = 0;
        chk("B_done_A_not_valid", 64'(bus.o_valid), 64'd0);
        chk("busy_two", 64'(bus.o_busy), 64'd1);
        tick();
        cmpl(0, 3'd0, 64'h1111_1111_1111_1111, 5'b00001);
        tick();
        bus.i_cmpl_valid = 0;
        bus.i_ready = 1;
        chk("A_valid",  64'(bus.o_valid), 64'd1);
        chk("A_result", bus.o_result, 64'h1111_1111_1111_1111);
        chk("A_fflags", 64'(bus.o_fflags), 64'b00001);
        tick();
        chk("B_valid",  64'(bus.o_valid), 64'd1);
        chk("B_result", bus.o_result, 64'h2222_2222_2222_2222);
        chk("acc_after_A", 64'(bus.o_fflags_acc), 64'b00001);
        tick();
        bus.i_ready = 0;
        chk("acc_after_B", 64'(bus.o_fflags_acc), 64'b10001);
        chk("AB_empty",    64'(bus.o_busy), 64'd0);
        chk("AB_valid0",   64'(bus.o_valid), 64'd0);

        // Flag clear concurrent with retire
        issue(0, 1);
        #1;
        chk("C_tag", 64'(bus.o_issue_tag), 64'd2);
        tick();
        bus.i_valid = 0;
        cmpl(0, 3'd2, 64'h3333, 5'b00100);
        tick();
        bus.i_cmpl_valid = 0;
        bus.i_ready = 1;
        bus.i_fflags_clr = 1;
        chk("C_fflags", 64'(bus.o_fflags), 64'b00100);
        tick();
        bus.i_ready = 0;
        bus.i_fflags_clr = 0;
        chk("acc_cleared", 64'(bus.o_fflags_acc), 64'd0);

        // NaN-boxing of a single-precision result, held while stalled
        issue(1, 0);
        #1;
        chk("D_tag", 64'(bus.o_issue_tag), 64'd3);
        tick();
        bus.i_valid = 0;
        cmpl(1, 3'd3, 64'hDEAD_BEEF_3F80_0000, 5'b01000);
        tick();
        bus.i_cmpl_valid = 0;
        chk("D_nanbox", bus.o_result, 64'hFFFF_FFFF_3F80_0000);
        held_res = bus.o_result;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("D_hold_valid",  64'(bus.o_valid), 64'd1);
            chk("D_hold_result", bus.o_result, held_res);
            chk("D_hold_fflags", 64'(bus.o_fflags), 64'b01000);
        end
        bus.i_ready = 1;
        tick();
        bus.i_ready = 0;
        chk("D_retired", 64'(bus.o_busy), 64'd0);

        // Fill to full, blocked fifth issue, retire while full
        for (int i = 0; i < 4; i++) begin
            issue(0, 1);
            tick();
        end
        chk("full_ready", 64'(bus.o_ready), 64'd0);
        #1;
        chk("full_no_launch", 64'(bus.o_unit_valid), 64'd0);
        cmpl(0, 3'd0, 64'h4444, 5'b00000);
        tick();
        bus.i_cmpl_valid = 0;
        bus.i_ready = 1;
        #1;
        chk("full_retire_valid",  64'(bus.o_valid), 64'd1);
        chk("full_retire_ready",  64'(bus.o_ready), 64'd0);
        chk("full_retire_launch", 64'(bus.o_unit_valid), 64'd0);
        tick();
        bus.i_ready = 0;
        #1;
        chk("after_retire_launch", 64'(bus.o_unit_valid), 64'b01);
        chk("after_retire_tag",    64'(bus.o_issue_tag), 64'd0);
        tick();
        bus.i_valid = 0;

        // Flush with ops in flight; stale completion must be dropped
        bus.i_flush = 1;
        issue(1, 1);
        #1;
        chk("flush_ready",  64'(bus.o_ready), 64'd0);
        chk("flush_launch", 64'(bus.o_unit_valid), 64'd0);
        tick();
        bus.i_flush = 0;
        bus.i_valid = 0;
        cmpl(1, 3'd1, 64'h5555, 5'b00010);
        #1;
        chk("flush_busy", 64'(bus.o_busy), 64'd0);
        tick();
        bus.i_cmpl_valid = 0;
        chk("stale_valid", 64'(bus.o_valid), 64'd0);
        chk("stale_busy",  64'(bus.o_busy), 64'd0);
        issue(1, 1);
        #1;
        chk("epoch1_launch", 64'(bus.o_unit_valid), 64'b10);
        chk("epoch1_tag",    64'(bus.o_issue_tag), 64'd4);
        tick();
        bus.i_valid = 0;

        // Reset mid-operation discards the in-flight entry
        rst_n = 0;
        #2;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        tick();
        rst_n = 1;
        cmpl(0, 3'd0, 64'h6666, 5'b00001);
        tick();
        bus.i_cmpl_valid = 0;
        chk("postrst_valid", 64'(bus.o_valid), 64'd0);
        chk("postrst_tag",   64'(bus.o_issue_tag), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/msrh_fpu_cmpl_buf.md
MSRH_FPU_CMPL_BUF -- requirements
Module: msrh_fpu_cmpl_buf

Interface
REQ-001 SHALL have parameter XLEN_W, default 64; datapath width, 32 or 64.
REQ-002 SHALL have parameter NUM_UNITS, default 2; number of FP sub-units that complete out of order.
REQ-003 SHALL have parameter DEPTH, default 4; in-flight entries, power of 2, at least 2.
REQ-004 SHALL use derived width IDX_W = $clog2(DEPTH) and TAG_W = IDX_W+1, where tag = {epoch, index}.
REQ-005 SHALL have port i_clk  in  1  single clock, rising edge.
REQ-006 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_valid  in  1  issue request.
REQ-008 SHALL have port o_ready  out  1  entry available.
REQ-009 SHALL have port i_unit_sel  in  $clog2(NUM_UNITS) (min 1)  target sub-unit.
REQ-010 SHALL have port i_size_dw  in  1  1 = double, 0 = single.
REQ-011 SHALL have port o_unit_valid  out  NUM_UNITS  one-hot launch strobe to the selected unit.
REQ-012 SHALL have port o_issue_tag  out  TAG_W  tag for the launched op.
REQ-013 SHALL have port i_cmpl_valid  in  NUM_UNITS  per-unit completion strobe.
REQ-014 SHALL have port i_cmpl_tag  in  NUM_UNITS*TAG_W  per-unit completion tag.
REQ-015 SHALL have port i_cmpl_result  in  NUM_UNITS*XLEN_W  per-unit result.
REQ-016 SHALL have port i_cmpl_fflags  in  NUM_UNITS*5  per-unit exception flags.
REQ-017 SHALL have port i_flush  in  1  kill all in-flight ops.
REQ-018 SHALL have port o_valid  out  1  in-order result available.
REQ-019 SHALL have port i_ready  in  1  consumer accepts the result.
REQ-020 SHALL have port o_result  out  XLEN_W  retired result.
REQ-021 SHALL have port o_fflags  out  5  retired op's flags.
REQ-022 SHALL have port o_fflags_acc  out  5  sticky OR of retired flags.
REQ-023 SHALL have port i_fflags_clr  in  1  clear o_fflags_acc.
REQ-024 SHALL have port o_busy  out  1  any entry allocated.

Function
REQ-025 SHALL keep a circular buffer of DEPTH entries, each holding {alloc, done, size_dw, result, fflags}, with head/tail pointers of IDX_W+1 bits (wrap bit).
REQ-026 SHALL define full = (idx equal and wrap differs) and empty = (pointers equal), and drive o_ready = !full & !i_flush.
REQ-027 SHALL, on issue (i_valid & o_ready), set entry[tail].alloc, clear done, store size, increment tail, and drive o_unit_valid[i_unit_sel]=1 with o_issue_tag={epoch, tail idx} in the same cycle (combinational).
REQ-028 SHALL drive o_unit_valid to all zeros when no issue occurs.
REQ-029 SHALL, on i_cmpl_valid[u], write result/fflags and set done for entry[idx] only if the tag epoch equals the current epoch and the entry is allocated and not done; otherwise the completion is dropped silently.
REQ-030 SHALL accept up to NUM_UNITS completions per cycle to distinct entries; two units completing the same tag in one cycle is illegal (bench assertion).
REQ-031 SHALL drive o_valid = entry[head].alloc & done from registered state, so a completion at edge N is visible on o_valid after edge N when that entry is head; o_valid has one cycle of latency.
REQ-032 SHALL, when o_valid and !size_dw and XLEN_W==64, NaN-box o_result: upper 32 bits all ones, lower 32 bits taken from result; when size_dw, o_result passes through unchanged.
REQ-033 SHALL hold o_valid, o_result and o_fflags stable until i_ready; on o_valid & i_ready, clear entry[head].alloc and increment head.
REQ-034 SHALL OR o_fflags into o_fflags_acc on each retire; i_fflags_clr takes priority over set in the same cycle, and clear-then-new-flags-next-cycle is the resulting order.
REQ-035 SHALL permit issue and retire in the same cycle; when full, issue is blocked that cycle even if retire occurs (no bypass).
REQ-036 SHALL, on i_flush, clear all alloc/done bits, set head=tail=0 and toggle epoch at the next edge; any issue/retire that same cycle is suppressed (o_ready=0, o_valid forced 0), and late completions carrying the old epoch are dropped.
REQ-037 SHALL drive o_busy = !empty.
REQ-038 SHALL support XLEN_W==32 with no NaN-boxing.

Reset
REQ-039 SHALL, while i_reset_n=0 (asynchronous), hold pointers=0, epoch=0, all alloc/done=0, and o_fflags_acc=0; outputs take o_ready=1, o_valid=0, o_busy=0, o_unit_valid=0, with o_result/o_fflags don't-care but driven from cleared state (0).
REQ-040 SHALL, when reset is asserted mid-operation, discard all in-flight entries; completions following deassertion are dropped unless allocated after reset.

Verification
REQ-041 SHALL cover: issue A(unit0), B(unit1); B completes cycle 3, A cycle 5 -> A retires cycle 6, B cycle 7, in order.
REQ-042 SHALL cover: DEPTH=4, 4 issues, no completions -> o_ready=0; fifth i_valid produces no o_unit_valid.
REQ-043 SHALL cover: single op, result 0x00000000_3F800000, size_dw=0 -> o_result=0xFFFFFFFF_3F800000.
REQ-044 SHALL cover: 2 ops in flight, i_flush, then old-tag completion -> dropped; o_valid stays 0; o_busy=0; next o_issue_tag epoch=1, idx=0.
REQ-045 SHALL cover: retire flags 5'b00001, then 5'b10000 -> o_fflags_acc=5'b10001; i_fflags_clr concurrent with retire of 5'b00100 -> acc=0.
REQ-046 SHALL cover: i_ready=0 for 3 cycles with head done -> o_result/o_fflags stable; full buffer plus simultaneous retire -> no issue that cycle, issue next cycle.
